// File: rtl/program_counter.sv
// Program counter with load, increment, call and return, plus an optional return-address stack.
// Define PC_STACK_EN to build the return stack; without it callPC acts as loadPC and retPC is ignored.
module program_counter #(
    parameter int               WIDTH        = 12,
    parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
    parameter int               STACK_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loadPC,
    input  logic             incPC,
    input  logic             callPC,
    input  logic             retPC,
    input  logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] execadd,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_s;
    logic [WIDTH-1:0] pc_inc_s;

    assign execadd  = pc_r;
    assign pc_inc_s = pc_r + {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef PC_STACK_EN
    localparam int             PTR_W     = $clog2(STACK_DEPTH);
    localparam logic [PTR_W:0] DEPTH_MAX = (PTR_W+1)'(STACK_DEPTH);
    localparam logic [PTR_W:0] ZERO      = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0] ONE       = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] stack_r [STACK_DEPTH];
    logic [PTR_W:0]   depth_r;
    logic [PTR_W:0]   depth_s;
    logic [PTR_W:0]   top_s;
    logic             push_s;
    logic             err_r;
    logic             err_s;
    logic             full_r;
    logic             empty_r;

    assign stack_full  = full_r;
    assign stack_empty = empty_r;
    assign stack_err   = err_r;

    // Request priority and next PC / stack depth / error flag
    always_comb begin
        pc_s    = pc_r;
        depth_s = depth_r;
        err_s   = err_r;
        push_s  = 1'b0;
        top_s   = depth_r - ONE;
        if (loadPC) begin
            pc_s = address;
        end else if (callPC) begin
            // The jump happens even when the push is refused
            pc_s = address;
            if (depth_r == DEPTH_MAX) begin
                err_s = 1'b1;
            end else begin
                push_s  = 1'b1;
                depth_s = depth_r + ONE;
            end
        end else if (retPC) begin
            if (depth_r == ZERO) begin
                err_s = 1'b1;
            end else begin
                pc_s    = stack_r[top_s[PTR_W-1:0]];
                depth_s = top_s;
            end
        end else if (incPC) begin
            pc_s = pc_inc_s;
        end else begin
            pc_s = pc_r;
        end
    end

    // PC, depth and flag registers; full/empty are registered decodes of the next depth
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= RESET_VECTOR;
            depth_r <= ZERO;
            err_r   <= 1'b0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            pc_r    <= pc_s;
            depth_r <= depth_s;
            err_r   <= err_s;
            full_r  <= (depth_s == DEPTH_MAX);
            empty_r <= (depth_s == ZERO);
        end
    end

    // Return-address storage; entries above the depth pointer are don't-care
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            stack_r[depth_r[PTR_W-1:0]] <= pc_inc_s;
        end
    end
`else
    logic unused_s;

    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_err   = 1'b0;
    assign unused_s    = retPC | (STACK_DEPTH < 2 ? 1'b1 : 1'b0);

    // Request priority without a stack: call is a plain jump
    always_comb begin
        pc_s = pc_r;
        if (loadPC || callPC) begin
            pc_s = address;
        end else if (incPC) begin
            pc_s = pc_inc_s;
        end else begin
            pc_s = pc_r;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_VECTOR;
        end else begin
            pc_r <= pc_s;
        end
    end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter; covers both PC_STACK_EN builds.
module tb_program_counter;

    logic        clk;
    logic        rst;
    logic        loadPC;
    logic        incPC;
    logic        callPC;
    logic        retPC;
    logic [11:0] address;
    logic [11:0] execadd;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_err;

    int checks = 0;
    int errors = 0;

    program_counter dut (
        .clk         (clk),
        .rst         (rst),
        .loadPC      (loadPC),
        .incPC       (incPC),
        .callPC      (callPC),
        .retPC       (retPC),
        .address     (address),
        .execadd     (execadd),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; loadPC = 1'b0; incPC = 1'b0; callPC = 1'b0; retPC = 1'b0;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; step(); idle();
    endtask

    task automatic do_load(input logic [11:0] a);
        idle(); loadPC = 1'b1; address = a; step(); idle();
    endtask

    task automatic test_reset();
        idle(); loadPC = 1'b1; address = 12'h5A5; step();
        do_reset();
        checks++; if (execadd !== 12'h000) begin errors++; $display("FAIL reset_pc got %h expected %h", execadd, 12'h000); end
        checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b expected 1", stack_empty); end
        checks++; if (stack_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b expected 0", stack_full); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", stack_err); end
    endtask

    task automatic test_load_hold();
        do_load(12'h123);
        checks++; if (execadd !== 12'h123) begin errors++; $display("FAIL load got %h expected %h", execadd, 12'h123); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (execadd !== 12'h123) begin errors++; $display("FAIL hold%0d got %h expected %h", i, execadd, 12'h123); end
        end
    endtask

    task automatic test_increment();
        do_reset();
        incPC = 1'b1; step(); idle();
        checks++; if (execadd !== 12'h001) begin errors++; $display("FAIL inc got %h expected %h", execadd, 12'h001); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (execadd !== 12'h001) begin errors++; $display("FAIL inc_hold%0d got %h expected %h", i, execadd, 12'h001); end
        end
        incPC = 1'b1; step(); step(); idle();
        checks++; if (execadd !== 12'h003) begin errors++; $display("FAIL inc_twice got %h expected %h", execadd, 12'h003); end
        do_load(12'hFFF);
        incPC = 1'b1; step(); idle();
        checks++; if (execadd !== 12'h000) begin errors++; $display("FAIL inc_wrap got %h expected %h", execadd, 12'h000); end
    endtask

    task automatic test_priority();
        do_load(12'h300);
        loadPC = 1'b1; incPC = 1'b1; address = 12'h055; step(); idle();
        checks++; if (execadd !== 12'h055) begin errors++; $display("FAIL load_over_inc got %h expected %h", execadd, 12'h055); end
        rst = 1'b1; loadPC = 1'b1; address = 12'h3AA; step(); idle();
        checks++; if (execadd !== 12'h000) begin errors++; $display("FAIL rst_over_load got %h expected %h", execadd, 12'h000); end
        loadPC = 1'b1; callPC = 1'b1; address = 12'h0C0; step(); idle();
        checks++; if (execadd !== 12'h0C0) begin errors++; $display("FAIL load_over_call got %h expected %h", execadd, 12'h0C0); end
        checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL load_over_call_empty got %b expected 1", stack_empty); end
    endtask

`ifdef PC_STACK_EN
    task automatic test_call_ret();
        do_reset();
        do_load(12'h010);
        callPC = 1'b1; address = 12'h200; step(); idle();
        checks++; if (execadd !== 12'h200) begin errors++; $display("FAIL call got %h expected %h", execadd, 12'h200); end
        checks++; if (stack_empty !== 1'b0) begin errors++; $display("FAIL call_empty got %b expected 0", stack_empty); end
        retPC = 1'b1; incPC = 1'b1; step(); idle();
        checks++; if (execadd !== 12'h011) begin errors++; $display("FAIL ret got %h expected %h", execadd, 12'h011); end
        checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got %b expected 1", stack_empty); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL ret_err got %b expected 0", stack_err); end
        // Return address wraps when calling from the top of the space
        do_load(12'hFFF);
        callPC = 1'b1; address = 12'h020; step(); retPC = 1'b1; callPC = 1'b0; step(); idle();
        checks++; if (execadd !== 12'h000) begin errors++; $display("FAIL call_wrap got %h expected %h", execadd, 12'h000); end
    endtask

    task automatic test_overflow();
        logic [11:0] ret_exp [4] = '{12'h301, 12'h201, 12'h101, 12'h001};
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            callPC = 1'b1; address = 12'(i * 256); step(); idle();
            checks++; if (stack_full !== (i == 4)) begin errors++; $display("FAIL full_after_call%0d got %b expected %b", i, stack_full, (i == 4)); end
        end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL err_before_ovf got %b expected 0", stack_err); end
        callPC = 1'b1; address = 12'h500; step(); idle();
        checks++; if (execadd !== 12'h500) begin errors++; $display("FAIL ovf_pc got %h expected %h", execadd, 12'h500); end
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b expected 1", stack_err); end
        checks++; if (stack_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b expected 1", stack_full); end
        for (int i = 0; i < 4; i++) begin
            retPC = 1'b1; step(); idle();
            checks++; if (execadd !== ret_exp[i]) begin errors++; $display("FAIL pop%0d got %h expected %h", i, execadd, ret_exp[i]); end
        end
        checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL pops_empty got %b expected 1", stack_empty); end
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b expected 1", stack_err); end
    endtask

    task automatic test_underflow();
        do_reset();
        do_load(12'h077);
        retPC = 1'b1; step(); idle();
        checks++; if (execadd !== 12'h077) begin errors++; $display("FAIL unf_pc got %h expected %h", execadd, 12'h077); end
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL unf_err got %b expected 1", stack_err); end
        step(); step();
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL unf_err_hold got %b expected 1", stack_err); end
        retPC = 1'b1; rst = 1'b1; step(); idle();
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b expected 0", stack_err); end
        checks++; if (execadd !== 12'h000) begin errors++; $display("FAIL rst_over_ret got %h expected %h", execadd, 12'h000); end
    endtask
`else
    task automatic test_no_stack();
        do_reset();
        do_load(12'h010);
        callPC = 1'b1; address = 12'h200; step(); idle();
        checks++; if (execadd !== 12'h200) begin errors++; $display("FAIL call_as_load got %h expected %h", execadd, 12'h200); end
        retPC = 1'b1; step(); idle();
        checks++; if (execadd !== 12'h200) begin errors++; $display("FAIL ret_ignored got %h expected %h", execadd, 12'h200); end
        retPC = 1'b1; incPC = 1'b1; step(); idle();
        checks++; if (execadd !== 12'h201) begin errors++; $display("FAIL ret_inc got %h expected %h", execadd, 12'h201); end
        for (int i = 0; i < 5; i++) begin
            callPC = 1'b1; address = 12'(i * 16 + 3); step(); idle();
        end
        checks++; if (execadd !== 12'h043) begin errors++; $display("FAIL calls_pc got %h expected %h", execadd, 12'h043); end
        checks++; if (stack_full !== 1'b0) begin errors++; $display("FAIL tied_full got %b expected 0", stack_full); end
        checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL tied_empty got %b expected 1", stack_empty); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL tied_err got %b expected 0", stack_err); end
    endtask
`endif

    initial begin
        idle();
        address = 12'h000;
        test_reset();
        test_load_hold();
        test_increment();
        test_priority();
`ifdef PC_STACK_EN
        test_call_ret();
        test_overflow();
        test_underflow();
`else
        test_no_stack();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
